// File: rtl/wb_stage.sv
// Writeback stage: one-entry register feeding the 32x32 register file write port.
// Optional same-cycle read forwarding is enabled with `define WB_BYPASS_EN.
module wb_stage #(
   parameter int          CNT_W       = 32,
   parameter logic [31:0] LINK_OFFSET = 32'd4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_regwrite,
   input  logic [4:0]       in_writereg,
   input  logic             in_memtoreg,
   input  logic             in_link,
   input  logic [1:0]       in_load_size,
   input  logic             in_load_unsigned,
   input  logic [31:0]      in_alu_result,
   input  logic [31:0]      in_mem_rdata,
   input  logic [31:0]      in_pc,
   input  logic             stall,
   input  logic             flush,
   output logic             RegWrite,
   output logic [4:0]       writereg,
   output logic [31:0]      writedata,
   output logic             wb_valid,
   output logic             misalign,
   output logic [CNT_W-1:0] retire_count
`ifdef WB_BYPASS_EN
   ,
   input  logic [4:0]       rf_readreg1,
   input  logic [4:0]       rf_readreg2,
   input  logic [31:0]      rf_readdata1,
   input  logic [31:0]      rf_readdata2,
   output logic [31:0]      fwd_readdata1,
   output logic [31:0]      fwd_readdata2
`endif
);

   logic        valid_q;
   logic        regwrite_q;
   logic [4:0]  writereg_q;
   logic        memtoreg_q;
   logic        link_q;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic [31:0] alu_q;
   logic [31:0] rdata_q;
   logic [31:0] pc_q;

   logic [1:0]  off;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_v;
   logic [31:0] sel_data;
   logic        is_half;
   logic        is_word;
   logic        retire;

   // Handshake: in_ready = !stall, independent of in_valid. An instruction
   // transfers on a rising edge where in_valid & in_ready & !flush.
   assign in_ready = !stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         writereg_q <= 5'd0;
         memtoreg_q <= 1'b0;
         link_q     <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         alu_q      <= 32'd0;
         rdata_q    <= 32'd0;
         pc_q       <= 32'd0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (in_valid && !stall) begin
         valid_q    <= 1'b1;
         regwrite_q <= in_regwrite;
         writereg_q <= in_writereg;
         memtoreg_q <= in_memtoreg;
         link_q     <= in_link;
         size_q     <= in_load_size;
         unsigned_q <= in_load_unsigned;
         alu_q      <= in_alu_result;
         rdata_q    <= in_mem_rdata;
         pc_q       <= in_pc;
      end else begin
         valid_q <= 1'b0;
      end
   end

   // Little-endian lane extraction; reserved size 2'b11 behaves as a word.
   always_comb begin
      off    = alu_q[1:0];
      byte_v = rdata_q[{off, 3'b000} +: 8];
      half_v = off[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (size_q)
         2'b00:   load_v = unsigned_q ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
         2'b01:   load_v = unsigned_q ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
         default: load_v = rdata_q;
      endcase
      if (link_q)          sel_data = pc_q + LINK_OFFSET;
      else if (memtoreg_q) sel_data = load_v;
      else                 sel_data = alu_q;
   end

   assign is_half  = (size_q == 2'b01);
   assign is_word  = size_q[1];
   assign misalign = valid_q & memtoreg_q & ((is_half & off[0]) | (is_word & (off != 2'b00)));
   assign RegWrite = valid_q & regwrite_q & (writereg_q != 5'd0) & !misalign;
   assign writereg  = valid_q ? writereg_q : 5'd0;
   assign writedata = valid_q ? sel_data : 32'd0;
   assign wb_valid  = valid_q;
   assign retire    = valid_q & !misalign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retire_count <= '0;
      else if (retire)
         retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
   end

`ifdef WB_BYPASS_EN
   // Decode sees this cycle's write before the register file captures it.
   assign fwd_readdata1 = (RegWrite && (writereg_q == rf_readreg1)) ? writedata : rf_readdata1;
   assign fwd_readdata2 = (RegWrite && (writereg_q == rf_readreg2)) ? writedata : rf_readdata2;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a transaction-level model.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_regwrite, in_memtoreg, in_link, in_load_unsigned;
   logic [4:0]  in_writereg;
   logic [1:0]  in_load_size;
   logic [31:0] in_alu_result, in_mem_rdata, in_pc;
   logic        stall, flush;
   logic        RegWrite, wb_valid, misalign;
   logic [4:0]  writereg;
   logic [31:0] writedata, retire_count;
`ifdef WB_BYPASS_EN
   logic [4:0]  rf_readreg1, rf_readreg2;
   logic [31:0] rf_readdata1, rf_readdata2, fwd_readdata1, fwd_readdata2;
`endif

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_regwrite(in_regwrite), .in_writereg(in_writereg), .in_memtoreg(in_memtoreg),
      .in_link(in_link), .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
      .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_pc(in_pc),
      .stall(stall), .flush(flush), .RegWrite(RegWrite), .writereg(writereg),
      .writedata(writedata), .wb_valid(wb_valid), .misalign(misalign),
      .retire_count(retire_count)
`ifdef WB_BYPASS_EN
      , .rf_readreg1(rf_readreg1), .rf_readreg2(rf_readreg2),
      .rf_readdata1(rf_readdata1), .rf_readdata2(rf_readdata2),
      .fwd_readdata1(fwd_readdata1), .fwd_readdata2(fwd_readdata2)
`endif
   );

   typedef struct {
      bit        v;
      bit        rw;
      bit [4:0]  rd;
      bit        mtr;
      bit        lnk;
      bit [1:0]  sz;
      bit        uns;
      bit [31:0] alu;
      bit [31:0] rdata;
      bit [31:0] pc;
   } ent_t;

   ent_t      held;
   bit [31:0] m_cnt;
   int        n_cmp = 0;
   int        n_bad = 0;
   int        n_writes;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic ent_t mk(bit rw, bit [4:0] rd, bit mtr, bit lnk, bit [1:0] sz,
                               bit uns, bit [31:0] alu, bit [31:0] rdata, bit [31:0] pc);
      ent_t e;
      e.v = 1; e.rw = rw; e.rd = rd; e.mtr = mtr; e.lnk = lnk; e.sz = sz;
      e.uns = uns; e.alu = alu; e.rdata = rdata; e.pc = pc;
      return e;
   endfunction

   function automatic ent_t idle();
      ent_t e;
      e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      e.v = 0;
      return e;
   endfunction

   function automatic bit [31:0] load_val(ent_t e);
      int unsigned off = e.alu % 4;
      bit [31:0] r;
      if (e.sz == 0) begin
         r = (e.rdata >> (8 * off)) % 256;
         if (!e.uns && r >= 128) r = r + 32'hFFFF_FF00;
      end else if (e.sz == 1) begin
         r = (off >= 2) ? (e.rdata >> 16) : (e.rdata % 65536);
         if (!e.uns && r >= 32768) r = r + 32'hFFFF_0000;
      end else begin
         r = e.rdata;
      end
      return r;
   endfunction

   function automatic bit is_mis(ent_t e);
      int unsigned off = e.alu % 4;
      return e.v && e.mtr && ((e.sz == 1 && off % 2 == 1) || (e.sz >= 2 && off != 0));
   endfunction

   function automatic bit [31:0] result(ent_t e);
      if (e.lnk) return e.pc + 32'd4;
      if (e.mtr) return load_val(e);
      return e.alu;
   endfunction

   task automatic check_outputs();
      bit        m  = is_mis(held);
      bit        we = held.v && held.rw && held.rd != 0 && !m;
      bit [31:0] d  = held.v ? result(held) : 32'd0;
      check("RegWrite", {31'd0, RegWrite}, {31'd0, we});
      check("writereg", {27'd0, writereg}, held.v ? {27'd0, held.rd} : 32'd0);
      check("writedata", writedata, d);
      check("wb_valid", {31'd0, wb_valid}, {31'd0, held.v});
      check("misalign", {31'd0, misalign}, {31'd0, m});
      check("retire_count", retire_count, m_cnt);
      if (RegWrite) n_writes++;
`ifdef WB_BYPASS_EN
      check("fwd1", fwd_readdata1, (we && held.rd == rf_readreg1) ? d : rf_readdata1);
      check("fwd2", fwd_readdata2, (we && held.rd == rf_readreg2) ? d : rf_readdata2);
`endif
   endtask

   // Called at a falling edge: drives one cycle, updates the model, checks at the next falling edge.
   task automatic step(input ent_t e, input bit st, input bit fl);
      in_valid = e.v; in_regwrite = e.rw; in_writereg = e.rd; in_memtoreg = e.mtr;
      in_link = e.lnk; in_load_size = e.sz; in_load_unsigned = e.uns;
      in_alu_result = e.alu; in_mem_rdata = e.rdata; in_pc = e.pc;
      stall = st; flush = fl;
      #1;
      check("in_ready", {31'd0, in_ready}, {31'd0, !st});
      @(posedge clk);
      if (held.v && !is_mis(held)) m_cnt = m_cnt + 1;
      if (fl) held.v = 0;
      else if (e.v && !st) held = e;
      else held.v = 0;
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      held = idle();
      m_cnt = 0;
      n_writes = 0;
`ifdef WB_BYPASS_EN
      rf_readreg1 = 0; rf_readreg2 = 0; rf_readdata1 = 0; rf_readdata2 = 0;
`endif
      rst_n = 1'b0;
      in_valid = 1; in_regwrite = 1; in_writereg = 5; in_memtoreg = 0; in_link = 0;
      in_load_size = 0; in_load_unsigned = 0; in_alu_result = 32'h1234_5678;
      in_mem_rdata = 0; in_pc = 0; stall = 0; flush = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      // ALU write, then retire count one edge later
      step(mk(1, 5, 0, 0, 2, 0, 32'h1234_5678, 0, 0), 0, 0);
      check("alu_wdata", writedata, 32'h1234_5678);
      step(idle(), 0, 0);
      check("cnt_after_alu", retire_count, 32'd1);

      // Byte and half loads with extension
      step(mk(1, 8, 1, 0, 0, 0, 32'h1003, 32'h80FF_0000, 0), 0, 0);
      check("lb", writedata, 32'hFFFF_FF80);
      step(mk(1, 8, 1, 0, 0, 1, 32'h1003, 32'h80FF_0000, 0), 0, 0);
      check("lbu", writedata, 32'h0000_0080);
      step(mk(1, 9, 1, 0, 1, 0, 32'h1002, 32'h8001_0000, 0), 0, 0);
      check("lh", writedata, 32'hFFFF_8001);

      // Misaligned half
      step(mk(1, 9, 1, 0, 1, 0, 32'h1001, 32'h8001_0000, 0), 0, 0);
      check("mis_half", {31'd0, misalign}, 32'd1);
      step(idle(), 0, 0);

      // Destination $0 and link
      step(mk(1, 0, 0, 0, 2, 0, 32'hAAAA_5555, 0, 0), 0, 0);
      check("r0_nowrite", {31'd0, RegWrite}, 32'd0);
      step(mk(1, 31, 0, 1, 2, 0, 32'h0, 0, 32'h0040_0010), 0, 0);
      check("link", writedata, 32'h0040_0014);

      // Stall for 3 cycles with a held entry: exactly one write
      step(mk(1, 3, 0, 0, 2, 0, 32'h0000_0033, 0, 0), 0, 0);
      n_writes = 1;
      for (int i = 0; i < 3; i++) step(mk(1, 4, 0, 0, 2, 0, 32'h44, 0, 0), 1, 0);
      check("stall_writes", n_writes, 32'd1);

      // Flush while capturing, both idle and with an entry held
      step(mk(1, 6, 0, 0, 2, 0, 32'h66, 0, 0), 0, 1);
      step(mk(1, 6, 0, 0, 2, 0, 32'h66, 0, 0), 0, 0);
      step(mk(1, 7, 0, 0, 2, 0, 32'h77, 0, 0), 0, 1);

`ifdef WB_BYPASS_EN
      rf_readreg1 = 7; rf_readdata1 = 0; rf_readreg2 = 0; rf_readdata2 = 32'h1111_2222;
      step(mk(1, 7, 0, 0, 2, 0, 32'hDEAD_BEEF, 0, 0), 0, 0);
      check("fwd_hit", fwd_readdata1, 32'hDEAD_BEEF);
      rf_readreg1 = 0; rf_readdata1 = 32'h0BAD_F00D;
      #1 check("fwd_r0", fwd_readdata1, 32'h0BAD_F00D);
`endif

      // Asynchronous reset mid-operation drops the pending write immediately
      step(mk(1, 12, 0, 0, 2, 0, 32'hCAFE_0001, 0, 0), 0, 0);
      rst_n = 1'b0;
      #1;
      check("async_rst_we", {31'd0, RegWrite}, 32'd0);
      check("async_rst_cnt", retire_count, 32'd0);
      held.v = 0;
      m_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         ent_t e;
         e = mk($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
                $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                $urandom, $urandom, $urandom);
         e.v = $urandom_range(0, 4) != 0;
`ifdef WB_BYPASS_EN
         rf_readreg1 = 5'($urandom_range(0, 31)); rf_readreg2 = 5'($urandom_range(0, 31));
         rf_readdata1 = $urandom; rf_readdata2 = $urandom;
`endif
         step(e, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
